// File: rtl/xadc_pkg.sv
// rtl/xadc_pkg.sv - shared widths, channel-code bases and FSM encoding for the XADC scan sequencer
package xadc_pkg;

  localparam int RESULT_W = 12;
  localparam int CH_W     = 5;
  localparam int BEAT_W   = 10;

  localparam logic [RESULT_W-1:0] TIMEOUT_DATA = 12'hFFF;

  localparam logic [CH_W-1:0] CH_PDO_BASE  = 5'h00;
  localparam logic [CH_W-1:0] CH_V1V2_BASE = 5'h10;
  localparam logic [CH_W-1:0] CH_TDO_BASE  = 5'h18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_EMIT,
    ST_GAP
  } scan_state_e;

  // True for codes inside one of the three populated channel groups (0x08-0x0F is unused).
  function automatic logic ch_is_known(input logic [CH_W-1:0] ch);
    logic [CH_W-1:0] grp;
    grp = ch & 5'h18;
    return (grp == CH_PDO_BASE) || (grp == CH_V1V2_BASE) || (grp == CH_TDO_BASE);
  endfunction

endpackage

// File: rtl/xadc_avg_acc.sv
// rtl/xadc_avg_acc.sv - conversion accumulator; avg is (acc + din) >> AVG_LOG2, valid on the final add
module xadc_avg_acc
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk125,
  input  logic                rst,
  input  logic                clr,
  input  logic                add,
  input  logic [RESULT_W-1:0] din,
  output logic [RESULT_W-1:0] avg
);

  localparam int ACC_W = RESULT_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;

  // Clear wins over add so the final sample can be folded into avg and the sum dropped in one cycle.
  always_comb begin
    sum   = acc_q + ACC_W'(din);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = sum;
    end
  end

  assign avg = RESULT_W'(sum >> AVG_LOG2);

  always_ff @(posedge clk125) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/xadc_scan_ctrl.sv
// rtl/xadc_scan_ctrl.sv - XADC scan sequencer: start/done handshake, result stream, done timeout
// Define XADC_SCAN_AVG_EN to average 2^AVG_LOG2 conversions per output beat.
module xadc_scan_ctrl
  import xadc_pkg::*;
#(
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int AVG_LOG2    = 2
) (
  input  logic                clk125,
  input  logic                rst,
  input  logic                req,
  input  logic [CH_W-1:0]     req_ch_sel,
  input  logic [BEAT_W-1:0]   req_count,
  input  logic                abort,
  output logic                busy,
  output logic                xadc_start,
  output logic [CH_W-1:0]     xadc_ch_sel,
  input  logic                xadc_done,
  input  logic [RESULT_W-1:0] xadc_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [RESULT_W-1:0] out_data,
  output logic                out_last,
  output logic                timeout_err
);

  localparam int TMO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  scan_state_e         state_q, state_d;
  logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
  logic [BEAT_W-1:0]   count_q, count_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                abort_q, abort_d;
  logic [RESULT_W-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                timeout_err_q, timeout_err_d;
  logic                is_final;

`ifdef XADC_SCAN_AVG_EN
  localparam int CNT_W = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic                acc_add;
  logic                acc_clr;
  logic [RESULT_W-1:0] acc_avg;

  xadc_avg_acc #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg_acc (
    .clk125 (clk125),
    .rst    (rst),
    .clr    (acc_clr),
    .add    (acc_add),
    .din    (xadc_result),
    .avg    (acc_avg)
  );
`else
  localparam int unused_avg_log2 = AVG_LOG2;
`endif

  // count of 0 wraps to 1023 here, which is what makes it mean 1024 beats.
  assign is_final = (beat_cnt_q == count_q - BEAT_W'(1)) || abort_q || abort;

  always_comb begin
    state_d       = state_q;
    ch_sel_d      = ch_sel_q;
    count_d       = count_q;
    beat_cnt_d    = beat_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    abort_d       = abort_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    timeout_err_d = timeout_err_q;
`ifdef XADC_SCAN_AVG_EN
    acc_cnt_d     = acc_cnt_q;
    acc_add       = 1'b0;
    acc_clr       = 1'b0;
`endif
    if (abort && (state_q != ST_IDLE)) begin
      abort_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          ch_sel_d      = req_ch_sel;
          count_d       = req_count;
          beat_cnt_d    = '0;
          abort_d       = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // done is tested first so a done landing on the timeout cycle still counts.
        if (xadc_done) begin
`ifdef XADC_SCAN_AVG_EN
          acc_add = 1'b1;
          if (acc_cnt_q != AVG_LAST) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            state_d   = ST_START;
          end else begin
            acc_cnt_d  = '0;
            acc_clr    = 1'b1;
            out_data_d = acc_avg;
            out_last_d = is_final;
            state_d    = ST_EMIT;
          end
`else
          out_data_d = xadc_result;
          out_last_d = is_final;
          state_d    = ST_EMIT;
`endif
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC)) begin
          timeout_err_d = 1'b1;
          out_data_d    = TIMEOUT_DATA;
          out_last_d    = 1'b1;
          state_d       = ST_EMIT;
`ifdef XADC_SCAN_AVG_EN
          acc_cnt_d     = '0;
          acc_clr       = 1'b1;
`endif
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (out_last_q) begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
          end else if (GAP_CYC == 0) begin
            state_d = ST_START;
          end else begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_START;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ch_sel_q      <= '0;
      count_q       <= '0;
      beat_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      abort_q       <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef XADC_SCAN_AVG_EN
      acc_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ch_sel_q      <= ch_sel_d;
      count_q       <= count_d;
      beat_cnt_q    <= beat_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      abort_q       <= abort_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      timeout_err_q <= timeout_err_d;
`ifdef XADC_SCAN_AVG_EN
      acc_cnt_q     <= acc_cnt_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign xadc_start  = (state_q == ST_START);
  assign xadc_ch_sel = ch_sel_q;
  assign out_valid   = (state_q == ST_EMIT);
  assign out_ch      = ch_sel_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign timeout_err = timeout_err_q;

endmodule
